stopwatch_counter: RTL and testbench

//  Timebase and BCD time register for the stopwatch, directly downstream of the control FSM.

---
 rtl/stopwatch_counter_pkg.sv | 19 +
 rtl/stopwatch_counter_bcd_digit.sv | 29 ++
 rtl/stopwatch_counter.sv | 75 +++++++
 tb/tb_stopwatch_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared stopwatch constants and BCD helpers, used by the counter, control FSM and display driver.
package stopwatch_counter_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;
    localparam int DEFAULT_TICK_HZ     = 100;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Out-of-range codes are treated as 9 so a corrupted digit self-heals on its next increment.
    function automatic bcd_t bcd_next(input bcd_t d);
        return (d >= BCD_MAX) ? '0 : bcd_t'(d + 4'd1);
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One decade of the stopwatch time register; chained through carry_in/carry_out.
module bcd_digit
    import stopwatch_counter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic carry_in,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t r_digit;

    // NOTE: asynchronous reset sits in the sensitivity list; the synchronous clear is an ordinary priority branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (carry_in) begin
            r_digit <= bcd_next(r_digit);
        end
    end

    assign digit     = r_digit;
    assign carry_out = carry_in & (r_digit >= BCD_MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timebase: divides clk to a centisecond tick and keeps elapsed time as SS.CC in BCD.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int TICK_HZ     = DEFAULT_TICK_HZ
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          init_regs,
    input  logic                          count_enabled,
    output logic [NUM_DIGITS*DIGIT_W-1:0] time_bcd,
    output logic                          tick,
    output logic                          wrapped
);

    localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
    localparam int PS_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("stopwatch_counter: CLK_FREQ_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [PS_W-1:0]               r_prescaler;
    logic                          r_tick;
    logic                          r_wrapped;
    logic                          w_inc;
    logic [NUM_DIGITS:0]           w_carry;
    logic [NUM_DIGITS*DIGIT_W-1:0] w_digits;

    // Clear outranks enable, so an init on a carry edge suppresses both the increment and the pulses.
    assign w_inc      = count_enabled & ~init_regs & (r_prescaler == PS_LAST);
    assign w_carry[0] = w_inc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescaler <= '0;
            r_tick      <= 1'b0;
            r_wrapped   <= 1'b0;
        end else if (init_regs) begin
            r_prescaler <= '0;
            r_tick      <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            // Pausing holds the prescaler so the sub-tick fraction survives a stop/start.
            if (count_enabled) begin
                r_prescaler <= w_inc ? '0 : PS_W'(r_prescaler + 1'b1);
            end
            r_tick    <= w_inc;
            r_wrapped <= w_carry[NUM_DIGITS];
        end
    end

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .reset_n   (reset_n),
                .clr       (init_regs),
                .carry_in  (w_carry[i]),
                .digit     (w_digits[i*DIGIT_W +: DIGIT_W]),
                .carry_out (w_carry[i+1])
            );
        end
    endgenerate

    assign time_bcd = w_digits;
    assign tick     = r_tick;
    assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with DIV=4; a decimal reference model feeds a scoreboard queue.
module tb_stopwatch_counter;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_regs = 1'b0;
    logic        count_enabled = 1'b0;
    logic [15:0] time_bcd;
    logic        tick;
    logic        wrapped;

    int n_cmp = 0;
    int n_mis = 0;

    int m_ps  = 0;
    int m_cnt = 0;

    logic [17:0] sb_q[$];
    logic        last_tick;
    logic        last_wrapped;

    stopwatch_counter #(
        .CLK_FREQ_HZ (40),
        .TICK_HZ     (10)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .time_bcd      (time_bcd),
        .tick          (tick),
        .wrapped       (wrapped)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int c);
        logic [15:0] r;
        r[15:12] = 4'(c / 1000);
        r[11:8]  = 4'((c / 100) % 10);
        r[7:4]   = 4'((c / 10) % 10);
        r[3:0]   = 4'(c % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advances the model for one edge and returns the expected {time_bcd, tick, wrapped}.
    function automatic logic [17:0] model_edge(input logic init, input logic en);
        logic e_tick;
        logic e_wrap;
        e_tick = 1'b0;
        e_wrap = 1'b0;
        if (init) begin
            m_ps  = 0;
            m_cnt = 0;
        end else if (en) begin
            if (m_ps == DIV - 1) begin
                m_ps   = 0;
                e_tick = 1'b1;
                e_wrap = (m_cnt == 9999);
                m_cnt  = (m_cnt + 1) % 10000;
            end else begin
                m_ps = m_ps + 1;
            end
        end
        return {to_bcd(m_cnt), e_tick, e_wrap};
    endfunction

    task automatic step(input logic init, input logic en, input string tag);
        logic [17:0] exp;
        @(negedge clk);
        init_regs     = init;
        count_enabled = en;
        sb_q.push_back(model_edge(init, en));
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        last_tick    = tick;
        last_wrapped = wrapped;
        check(tag, {14'd0, time_bcd, tick, wrapped}, {14'd0, exp});
    endtask

    initial begin
        int ticks;
        int first;

        // 1. Reset and idle
        #12;
        check("reset_state", {14'd0, time_bcd, tick, wrapped}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, "idle");
            if (last_tick) ticks++;
        end
        check("idle_ticks", ticks, 0);

        // 2. Forty enabled cycles give ten ticks
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, "run40");
            if (last_tick) ticks++;
        end
        check("run40_ticks", ticks, 10);
        check("run40_time", {16'd0, time_bcd}, 32'h0010);

        // 3. Pause keeps the sub-tick fraction
        step(1'b0, 1'b1, "pre_pause");
        step(1'b0, 1'b1, "pre_pause");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, "paused");
        check("paused_tick", {31'd0, last_tick}, 32'd0);
        first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            step(1'b0, 1'b1, "resume");
            if (last_tick) first = i;
        end
        check("resume_latency", first, 2);

        // Enable dropped exactly when the prescaler is at its last count
        step(1'b1, 1'b0, "clr_a");
        for (int i = 0; i < DIV - 1; i++) step(1'b0, 1'b1, "to_last");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold_last");
        step(1'b0, 1'b1, "fire_on_resume");
        check("fire_on_resume_tick", {31'd0, last_tick}, 32'd1);

        // 4. Full range and rollover
        step(1'b1, 1'b0, "clr_b");
        for (int i = 0; i < DIV * 9999; i++) step(1'b0, 1'b1, "long_run");
        check("at_9999", {16'd0, time_bcd}, 32'h9999);
        for (int i = 0; i < DIV; i++) step(1'b0, 1'b1, "wrap");
        check("wrap_time", {16'd0, time_bcd}, 32'h0000);
        check("wrap_pulses", {30'd0, last_tick, last_wrapped}, 32'd3);
        step(1'b0, 1'b1, "post_wrap");
        check("post_wrap_pulse", {31'd0, last_wrapped}, 32'd0);

        // 5. Init on the carry edge of 05.99
        step(1'b1, 1'b0, "clr_c");
        for (int i = 0; i < DIV * 599 + DIV - 1; i++) step(1'b0, 1'b1, "to_0599");
        check("at_0599", {16'd0, time_bcd}, 32'h0599);
        step(1'b1, 1'b1, "init_on_carry");
        check("init_on_carry_pulses", {30'd0, last_tick, last_wrapped}, 32'd0);

        // 6. Asynchronous reset mid-period at 12.34
        for (int i = 0; i < DIV * 1234 + 2; i++) step(1'b0, 1'b1, "to_1234");
        check("at_1234", {16'd0, time_bcd}, 32'h1234);
        #2;
        reset_n       = 1'b0;
        count_enabled = 1'b0;
        m_ps  = 0;
        m_cnt = 0;
        #1;
        check("async_reset", {14'd0, time_bcd, tick, wrapped}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "post_reset_idle");
        first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            step(1'b0, 1'b1, "post_reset_run");
            if (last_tick) first = i;
        end
        check("post_reset_latency", first, DIV);
        check("post_reset_time", {16'd0, time_bcd}, 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
